cfs_event_detect: RTL and testbench

CFS_EVENT_DETECT -- requirements
Module: cfs_event_detect

---
 rtl/cfs_event_detect_pkg.sv | 9 +
 rtl/cfs_event_detect_if.sv | 14 +
 rtl/cfs_event_detect_chan.sv | 68 ++++++
 rtl/cfs_event_detect.sv | 45 ++++
 tb/tb_cfs_event_detect.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/cfs_event_detect_pkg.sv
// cfs_event_detect_pkg: edge-mode encoding and parameter limits for the event detector
package cfs_event_detect_pkg;
  typedef enum logic [1:0] {OFF = 2'b00, RISE = 2'b01, FALL = 2'b10, BOTH = 2'b11} edge_mode_t;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;
  localparam int SYNC_MAX = 4;
  localparam int FILTER_MIN = 1;
  localparam int FILTER_MAX = 255;
endpackage

// File: rtl/cfs_event_detect_if.sv
// cfs_event_detect_if: channel inputs, controls and event outputs of the detector
interface cfs_event_detect_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data;
  logic [2*WIDTH-1:0] mode;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] detected;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] ovf;
  logic irq;
  modport master (output data, mode, irq_en, clr, input level, detected, status, ovf, irq);
  modport slave (input data, mode, irq_en, clr, output level, detected, status, ovf, irq);
endinterface

// File: rtl/cfs_event_detect_chan.sv
// cfs_event_detect_chan: one channel - synchroniser, debounce filter, edge qualify, sticky status/ovf
module cfs_event_detect_chan
  import cfs_event_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 4,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       data_i,
  input  edge_mode_t mode_i,
  input  logic       clr_i,
  output logic       level_o,
  output logic       detected_o,
  output logic       status_o,
  output logic       ovf_o
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  if (SYNC_STAGES < 0 || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end
  if (FILTER_LEN < FILTER_MIN || FILTER_LEN > FILTER_MAX) begin : g_bad_filter
    $error("FILTER_LEN out of range");
  end
  logic sync_w;
  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync_w = data_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) sync_q <= {SYNC_STAGES{RESET_VAL}};
      else sync_q <= SYNC_STAGES'({sync_q, data_i});
    assign sync_w = sync_q[SYNC_STAGES-1];
  end
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, det_q, det_d, status_q, status_d, ovf_q, ovf_d;
  logic diff, fire, match;
  always_comb begin
    diff = sync_w != level_q;
    fire = diff && cnt_q == CW'(FILTER_LEN - 1);
    match = sync_w ? (mode_i == RISE || mode_i == BOTH) : (mode_i == FALL || mode_i == BOTH);
    cnt_d = (diff && !fire) ? cnt_q + CW'(1) : '0;
    level_d = fire ? sync_w : level_q;
    det_d = fire && match;
    // a new event outranks a same-cycle clear
    status_d = det_q | (status_q & ~clr_i);
    ovf_d = (det_q & status_q) | (ovf_q & ~clr_i);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      level_q <= RESET_VAL;
      det_q <= 1'b0;
      status_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      level_q <= level_d;
      det_q <= det_d;
      status_q <= status_d;
      ovf_q <= ovf_d;
    end
  assign level_o = level_q;
  assign detected_o = det_q;
  assign status_o = status_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/cfs_event_detect.sv
// cfs_event_detect: WIDTH independent debounced edge-detect channels with a registered irq
module cfs_event_detect
  import cfs_event_detect_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 4,
  parameter logic RESET_VAL = 1'b0
) (
  input logic clk,
  input logic reset_n,
  cfs_event_detect_if.slave bus
);
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("WIDTH out of range");
  end
  logic [WIDTH-1:0] level_w, det_w, status_w, ovf_w;
  logic irq_q, irq_d;
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    cfs_event_detect_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN(FILTER_LEN),
      .RESET_VAL(RESET_VAL)
    ) u_chan (
      .clk(clk),
      .reset_n(reset_n),
      .data_i(bus.data[i]),
      .mode_i(edge_mode_t'(bus.mode[2*i +: 2])),
      .clr_i(bus.clr[i]),
      .level_o(level_w[i]),
      .detected_o(det_w[i]),
      .status_o(status_w[i]),
      .ovf_o(ovf_w[i])
    );
  end
  always_comb irq_d = |(status_w & bus.irq_en);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) irq_q <= 1'b0;
    else irq_q <= irq_d;
  assign bus.level = level_w;
  assign bus.detected = det_w;
  assign bus.status = status_w;
  assign bus.ovf = ovf_w;
  assign bus.irq = irq_q;
endmodule

// File: tb/tb_cfs_event_detect.sv
// tb_cfs_event_detect: directed checks of filter latency, glitch rejection, modes, sticky flags and reset
module tb_cfs_event_detect;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int checks = 0;
  int errors = 0;
  int p;
  cfs_event_detect_if #(.WIDTH(8)) bus();
  cfs_event_detect #(.WIDTH(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic watch(input int n, input int ch, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      tick(1);
      pulses += int'(bus.detected[ch]);
    end
  endtask
  initial begin
    bus.data = '0;
    bus.mode = '0;
    bus.irq_en = '0;
    bus.clr = '0;
    #1 reset_n = 1'b0;
    tick(2);
    chk("rst_level", bus.level, 0);
    chk("rst_det", bus.detected, 0);
    chk("rst_status", bus.status, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_irq", bus.irq, 0);
    #2 reset_n = 1'b1;
    tick(3);
    // ch0 rise: level/detected in cycle 6, status 7, irq 8
    bus.mode[1:0] = 2'b01;
    bus.irq_en[0] = 1'b1;
    bus.data[0] = 1'b1;
    tick(5);
    chk("c5_level", bus.level, 8'h00);
    tick(1);
    chk("c6_level", bus.level, 8'h01);
    chk("c6_det", bus.detected, 8'h01);
    chk("c6_status", bus.status, 8'h00);
    tick(1);
    chk("c7_det", bus.detected, 8'h00);
    chk("c7_status", bus.status, 8'h01);
    chk("c7_irq", bus.irq, 0);
    tick(1);
    chk("c8_irq", bus.irq, 1);
    bus.clr[0] = 1'b1;
    tick(1);
    bus.clr[0] = 1'b0;
    chk("clr0_status", bus.status, 8'h00);
    tick(1);
    chk("clr0_irq", bus.irq, 0);
    // ch4 3-cycle glitch rejected, ch5 4-cycle pulse accepted
    bus.mode[9:8] = 2'b01;
    bus.data[4] = 1'b1;
    tick(3);
    bus.data[4] = 1'b0;
    watch(12, 4, p);
    chk("glitch3_pulses", p, 0);
    chk("glitch3_level", bus.level[4], 0);
    chk("glitch3_status", bus.status[4], 0);
    bus.mode[11:10] = 2'b01;
    bus.data[5] = 1'b1;
    tick(4);
    bus.data[5] = 1'b0;
    watch(15, 5, p);
    chk("pulse4_pulses", p, 1);
    chk("pulse4_level", bus.level[5], 0);
    chk("pulse4_status", bus.status[5], 1);
    // ch1 both edges without clear -> ovf
    bus.mode[3:2] = 2'b11;
    bus.data[1] = 1'b1;
    watch(20, 1, p);
    chk("both_rise_pulses", p, 1);
    chk("both_rise_ovf", bus.ovf[1], 0);
    bus.data[1] = 1'b0;
    watch(20, 1, p);
    chk("both_fall_pulses", p, 1);
    chk("both_status", bus.status[1], 1);
    chk("both_ovf", bus.ovf[1], 1);
    bus.clr[1] = 1'b1;
    tick(1);
    bus.clr[1] = 1'b0;
    chk("clr1_status", bus.status[1], 0);
    chk("clr1_ovf", bus.ovf[1], 0);
    // ch2 fall-only sees no rise; mode off still tracks level
    bus.mode[5:4] = 2'b10;
    bus.data[2] = 1'b1;
    watch(12, 2, p);
    chk("fall_mode_rise_pulses", p, 0);
    chk("fall_mode_level", bus.level[2], 1);
    bus.mode[5:4] = 2'b00;
    bus.data[2] = 1'b0;
    watch(12, 2, p);
    chk("off_mode_pulses", p, 0);
    chk("off_mode_level", bus.level[2], 0);
    chk("off_mode_status", bus.status[2], 0);
    // mode change alone on ch6 makes no event
    bus.mode[13:12] = 2'b11;
    watch(10, 6, p);
    chk("mode_only_pulses", p, 0);
    chk("mode_only_status", bus.status[6], 0);
    // ch3 set and clear coincide: set wins, no ovf
    bus.mode[7:6] = 2'b01;
    bus.data[3] = 1'b1;
    tick(6);
    chk("setclr_det", bus.detected[3], 1);
    bus.clr[3] = 1'b1;
    tick(1);
    bus.clr[3] = 1'b0;
    chk("setclr_status", bus.status[3], 1);
    chk("setclr_ovf", bus.ovf[3], 0);
    // async reset with ch7 mid-filter (cnt=2 in cycle 4)
    bus.irq_en = 8'hFF;
    bus.mode[15:14] = 2'b01;
    bus.data[7] = 1'b1;
    tick(4);
    chk("prerst_irq", bus.irq, 1);
    chk("prerst_level", bus.level, 8'h09);
    #3 reset_n = 1'b0;
    bus.data = '0;
    #1;
    chk("arst_level", bus.level, 0);
    chk("arst_det", bus.detected, 0);
    chk("arst_status", bus.status, 0);
    chk("arst_ovf", bus.ovf, 0);
    chk("arst_irq", bus.irq, 0);
    tick(2);
    #2 reset_n = 1'b1;
    watch(12, 7, p);
    chk("postrst_pulses", p, 0);
    chk("postrst_level", bus.level, 0);
    chk("postrst_status", bus.status, 0);
    // all channels fire together
    bus.mode = 16'hFFFF;
    bus.data = 8'hFF;
    tick(6);
    chk("all_det", bus.detected, 8'hFF);
    chk("all_level", bus.level, 8'hFF);
    tick(1);
    chk("all_status", bus.status, 8'hFF);
    chk("all_ovf", bus.ovf, 8'h00);
    tick(1);
    chk("all_irq", bus.irq, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
